fir_channel_scheduler: RTL and testbench

Sequences one shared FIR filter instance across the left and right audio channels, so a single coefficient/MAC datapath serves both channels. Sits between the audio codec's read/write handshake and the filter. It pops a stereo sample pair, runs left then right through the filter with a start/done handshake, then presents the filtered pair to the codec as a single write. A bypass input routes samples straight through unfiltered.

---
 rtl/fir_sched_pkg.sv | 23 ++
 rtl/fir_wait_timer.sv | 36 +++
 rtl/fir_channel_scheduler.sv | 148 ++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | fir_sched_pkg -- shared state encoding and channel selects for the FIR   |
// | channel scheduler.                                        Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

package fir_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN_L  = 3'd1,
      S_WAIT_L = 3'd2,
      S_RUN_R  = 3'd3,
      S_WAIT_R = 3'd4,
      S_WRITE  = 3'd5
   } state_t;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fir_wait_timer.sv
// +--------------------------------------------------------------------------+
// | fir_wait_timer -- clearable wait counter, flags when it reaches TIMEOUT. |
// |                                                           Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_wait_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic i_ck,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   // Holds at TIMEOUT rather than wrapping, so expired stays asserted until cleared.
   always_ff @(posedge i_ck) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == CNT_W'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/fir_channel_scheduler.sv
// +--------------------------------------------------------------------------+
// | fir_channel_scheduler -- time-shares one FIR across left/right channels. |
// |                                                           Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_channel_scheduler
   import fir_sched_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic              i_ck,
   input  logic              i_rst_n,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample_left,
   input  logic [DATA_W-1:0] i_sample_right,
   output logic              o_sample_read,
   input  logic              i_bypass,
   output logic [DATA_W-1:0] o_fir_in,
   output logic              o_fir_start,
   output logic              o_fir_sel,
   input  logic [DATA_W-1:0] i_fir_out,
   input  logic              i_fir_done,
   input  logic              i_write_ready,
   output logic [DATA_W-1:0] o_out_left,
   output logic [DATA_W-1:0] o_out_right,
   output logic              o_write,
   output logic              o_busy,
   output logic              o_timeout_err
);

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_smp_l;
   logic [DATA_W-1:0] r_smp_r;
   logic [DATA_W-1:0] r_out_l;
   logic [DATA_W-1:0] r_out_r;
   logic              r_err;
   logic              w_accept;
   logic              w_write;
   logic              w_in_run;
   logic              w_in_wait;
   logic              w_expired;

   assign w_accept  = (r_state == S_IDLE) && i_sample_valid;
   assign w_write   = (r_state == S_WRITE) && i_write_ready;
   assign w_in_run  = (r_state == S_RUN_L) || (r_state == S_RUN_R);
   assign w_in_wait = (r_state == S_WAIT_L) || (r_state == S_WAIT_R);

   fir_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .i_ck      (i_ck),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_in_run),
      .i_en      (w_in_wait),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_ck) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_sample_valid) w_next = i_bypass ? S_WRITE : S_RUN_L;
         S_RUN_L:  w_next = S_WAIT_L;
         S_WAIT_L: if (i_fir_done || w_expired) w_next = S_RUN_R;
         S_RUN_R:  w_next = S_WAIT_R;
         S_WAIT_R: if (i_fir_done || w_expired) w_next = S_WRITE;
         S_WRITE:  if (i_write_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // A done arriving in the same cycle as expiry wins, so no error is flagged.
   always_ff @(posedge i_ck) begin
      if (!i_rst_n) begin
         r_smp_l <= '0;
         r_smp_r <= '0;
         r_out_l <= '0;
         r_out_r <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_smp_l <= i_sample_left;
            r_smp_r <= i_sample_right;
            if (i_bypass) begin
               r_out_l <= i_sample_left;
               r_out_r <= i_sample_right;
            end
         end
         if (r_state == S_WAIT_L) begin
            if (i_fir_done) begin
               r_out_l <= i_fir_out;
            end else if (w_expired) begin
               r_out_l <= '0;
               r_err   <= 1'b1;
            end
         end
         if (r_state == S_WAIT_R) begin
            if (i_fir_done) begin
               r_out_r <= i_fir_out;
            end else if (w_expired) begin
               r_out_r <= '0;
               r_err   <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_sample_read = w_accept && i_rst_n;
      o_write       = w_write;
      o_busy        = (r_state != S_IDLE);
      o_fir_start   = 1'b0;
      o_fir_in      = '0;
      o_fir_sel     = CH_LEFT;
      case (r_state)
         S_RUN_L: begin
            o_fir_start = 1'b1;
            o_fir_in    = r_smp_l;
            o_fir_sel   = CH_LEFT;
         end
         S_WAIT_L: o_fir_sel = CH_LEFT;
         S_RUN_R: begin
            o_fir_start = 1'b1;
            o_fir_in    = r_smp_r;
            o_fir_sel   = CH_RIGHT;
         end
         S_WAIT_R: o_fir_sel = CH_RIGHT;
         default: ;
      endcase
   end

   assign o_out_left    = r_out_l;
   assign o_out_right   = r_out_r;
   assign o_timeout_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_fir_channel_scheduler -- scoreboard bench with a D=3 filter model.    |
// |                                                           Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fir_channel_scheduler;

   logic        ck = 1'b0;
   logic        rst_n;
   logic        sample_valid;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        sample_read;
   logic        bypass;
   logic [15:0] fir_in;
   logic        fir_start;
   logic        fir_sel;
   logic [15:0] fir_out;
   logic        fir_done;
   logic        write_ready;
   logic [15:0] out_left;
   logic [15:0] out_right;
   logic        write_o;
   logic        busy;
   logic        timeout_err;

   always #5 ck = ~ck;

   fir_channel_scheduler #(
      .DATA_W  (16),
      .TIMEOUT (8)
   ) dut (
      .i_ck           (ck),
      .i_rst_n        (rst_n),
      .i_sample_valid (sample_valid),
      .i_sample_left  (sample_left),
      .i_sample_right (sample_right),
      .o_sample_read  (sample_read),
      .i_bypass       (bypass),
      .o_fir_in       (fir_in),
      .o_fir_start    (fir_start),
      .o_fir_sel      (fir_sel),
      .i_fir_out      (fir_out),
      .i_fir_done     (fir_done),
      .i_write_ready  (write_ready),
      .o_out_left     (out_left),
      .o_out_right    (out_right),
      .o_write        (write_o),
      .o_busy         (busy),
      .o_timeout_err  (timeout_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge ck) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          c;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   starts[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Filter model: fixed latency 3, left result = x^A5A5, right = x^5A5A.
   logic        m_done = 1'b0;
   logic [15:0] m_out  = '0;
   logic [15:0] m_res  = '0;
   int          m_cnt  = 0;
   logic        mute_l = 1'b0;
   logic        spur_done = 1'b0;
   logic [15:0] spur_val  = '0;

   assign fir_done = m_done | spur_done;
   assign fir_out  = spur_done ? spur_val : m_out;

   always @(posedge ck) begin
      #1;
      m_done = 1'b0;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_done = 1'b1;
            m_out  = m_res;
         end
      end
      if (fir_start && !(mute_l && fir_sel == 1'b0)) begin
         m_cnt = 3;
         m_res = fir_sel ? (fir_in ^ 16'h5A5A) : (fir_in ^ 16'hA5A5);
      end
   end

   always @(negedge ck) begin
      if (fir_start) starts.push_back(cyc);
      if (write_o) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got write=1 expected no write (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_left",    out_left,    e.l);
            chk("out_right",   out_right,   e.r);
            chk("write_cycle", cyc,         e.c);
            chk("timeout_err", timeout_err, e.err);
         end
      end
   end

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic accept(input logic [15:0] l, input logic [15:0] r, input logic byp,
                         input logic [15:0] el, input logic [15:0] er, input int dwr,
                         input logic e_err, input logic push, output int c0);
      sample_valid = 1'b1;
      sample_left  = l;
      sample_right = r;
      bypass       = byp;
      c0           = cyc;
      if (push) sb.push_back('{l: el, r: er, c: c0 + dwr, err: e_err});
      @(negedge ck);
      chk("sample_read_c0", sample_read, 1);
      tick();
      sample_valid = 1'b0;
      bypass       = 1'b0;
      @(negedge ck);
      chk("sample_read_c1", sample_read, 0);
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge ck);
         n++;
      end
      chk({name, "_idle"}, busy, 0);
      chk({name, "_sb_empty"}, sb.size(), 0);
      tick();
   endtask

   task automatic check_starts(int c0, int a, int b, int n);
      chk("start_count", starts.size(), n);
      if (n >= 1 && starts.size() >= 1) chk("start_left_cycle", starts[0], c0 + a);
      if (n >= 2 && starts.size() >= 2) chk("start_right_cycle", starts[1], c0 + b);
      starts.delete();
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_sample_read"}, sample_read, 0);
      chk({tag, "_fir_in"},      fir_in,      0);
      chk({tag, "_fir_start"},   fir_start,   0);
      chk({tag, "_fir_sel"},     fir_sel,     0);
      chk({tag, "_out_left"},    out_left,    0);
      chk({tag, "_out_right"},   out_right,   0);
      chk({tag, "_write"},       write_o,     0);
      chk({tag, "_busy"},        busy,        0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 200000 time units");
      $fatal(1);
   end

   initial begin
      int c0;
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample_left  = '0;
      sample_right = '0;
      bypass       = 1'b0;
      write_ready  = 1'b1;
      repeat (3) tick();
      @(negedge ck);
      chk_zero("reset");
      rst_n = 1'b1;
      tick();
      starts.delete();

      // Nominal filtered pair
      accept(16'h1234, 16'hFEDC, 1'b0, 16'hB791, 16'hA486, 9, 1'b0, 1'b1, c0);
      wait_idle("nominal");
      check_starts(c0, 1, 5, 2);

      // Bypass
      accept(16'h0100, 16'h8000, 1'b1, 16'h0100, 16'h8000, 1, 1'b0, 1'b1, c0);
      wait_idle("bypass");
      check_starts(c0, 0, 0, 0);

      // Spurious done in IDLE, then during accept and RUN_L
      spur_val  = 16'hDEAD;
      spur_done = 1'b1;
      tick();
      @(negedge ck);
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_out_left", out_left, 16'h0100);
      tick();
      accept(16'h0F0F, 16'h1357, 1'b0, 16'hAAAA, 16'h490D, 9, 1'b0, 1'b1, c0);
      spur_done = 1'b0;
      wait_idle("spurious");
      check_starts(c0, 1, 5, 2);

      // Write back-pressure for 50 cycles with sample_valid held high
      write_ready = 1'b0;
      accept(16'h4321, 16'h8765, 1'b0, 16'hE684, 16'hDD3F, 59, 1'b0, 1'b1, c0);
      repeat (8) tick();
      sample_valid = 1'b1;
      sample_left  = 16'h7777;
      sample_right = 16'h7777;
      for (int i = 0; i < 50; i++) begin
         @(negedge ck);
         chk("stall_busy",        busy,        1);
         chk("stall_write",       write_o,     0);
         chk("stall_sample_read", sample_read, 0);
         chk("stall_out_left",    out_left,    16'hE684);
         chk("stall_out_right",   out_right,   16'hDD3F);
         tick();
      end
      sample_valid = 1'b0;
      write_ready  = 1'b1;
      wait_idle("stall");
      check_starts(c0, 1, 5, 2);

      // Left channel never answers
      mute_l = 1'b1;
      accept(16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h7878, 15, 1'b1, 1'b1, c0);
      wait_idle("timeout");
      mute_l = 1'b0;
      check_starts(c0, 1, 11, 2);
      chk("timeout_err_set", timeout_err, 1);

      // Error flag is sticky across a clean transaction
      accept(16'h1234, 16'hFEDC, 1'b0, 16'hB791, 16'hA486, 9, 1'b1, 1'b1, c0);
      wait_idle("sticky");
      check_starts(c0, 1, 5, 2);

      // Reset while waiting on the right channel
      accept(16'h5555, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, c0);
      repeat (5) tick();
      @(negedge ck);
      chk("pre_reset_fir_sel", fir_sel, 1);
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      @(negedge ck);
      chk_zero("midreset");
      rst_n = 1'b1;
      repeat (3) tick();
      starts.delete();

      // Normal pair after reset
      accept(16'h0F0F, 16'h1357, 1'b0, 16'hAAAA, 16'h490D, 9, 1'b0, 1'b1, c0);
      wait_idle("post_reset");
      check_starts(c0, 1, 5, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
